// File: rtl/pkt_sf_fifo_pkg.sv
// pkt_sf_fifo_pkg: input FSM states and the layout of the flag bits stored
// above the payload in every FIFO entry.
package pkt_sf_fifo_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;
    localparam int SOP_BIT = 1;
    localparam int EOP_BIT = 0;
endpackage

// File: rtl/pkt_sf_ram.sv
// pkt_sf_ram: simple dual-port RAM with one write port and a registered read port.
module pkt_sf_ram #(
    parameter int W     = 10,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd_q <= mem[ra];
    end

    assign rd_data = rd_q;
endmodule

// File: rtl/pkt_sf_fifo.sv
// pkt_sf_fifo: store-and-forward packet FIFO; a packet becomes readable only once
// its eop beat commits, and overflowing or aborted packets are dropped whole.
module pkt_sf_fifo
    import pkt_sf_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_vld,
    input  logic                   din_sop,
    input  logic                   din_eop,
    input  logic [DATA_W-1:0]      din,
    input  logic                   b_rdy,
    output logic                   dout_vld,
    output logic                   dout_sop,
    output logic                   dout_eop,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_W + 2;

    state_t           state_q, state_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_commit_q, wr_commit_d, wr_tent_q, wr_tent_d;
    logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]   drop_sum;
    logic [DEPTH-1:0] eop_q, eop_d;
    logic             dout_vld_q, dout_vld_d;
    logic             rd_issue, rd_eop, we, commit, full_c, full_t;
    logic [1:0]       drop_inc;
    logic [AW-1:0]    wa;
    logic [EW-1:0]    rd_data;

    assign full_c = (wr_commit_q - rd_ptr_q) == PW'(DEPTH);
    assign full_t = (wr_tent_q - rd_ptr_q) == PW'(DEPTH);

    always_comb begin
        state_d     = state_q;
        wr_commit_d = wr_commit_q;
        wr_tent_d   = wr_tent_q;
        we          = 1'b0;
        wa          = wr_tent_q[AW-1:0];
        commit      = 1'b0;
        drop_inc    = 2'd0;
        if (din_vld && din_sop) begin
            // an unfinished packet is aborted; the new one always starts at wr_commit
            drop_inc  = {1'b0, state_q != IDLE};
            wr_tent_d = wr_commit_q;
            if (full_c) begin
                state_d  = din_eop ? IDLE : DISCARD;
                drop_inc = drop_inc + {1'b0, din_eop};
            end else begin
                we        = 1'b1;
                wa        = wr_commit_q[AW-1:0];
                wr_tent_d = wr_commit_q + 1'b1;
                state_d   = din_eop ? IDLE : WRITE;
                commit    = din_eop;
                if (din_eop) wr_commit_d = wr_commit_q + 1'b1;
            end
        end else if (din_vld && state_q == WRITE) begin
            if (full_t) begin
                wr_tent_d = wr_commit_q;
                state_d   = din_eop ? IDLE : DISCARD;
                drop_inc  = {1'b0, din_eop};
            end else begin
                we        = 1'b1;
                wr_tent_d = wr_tent_q + 1'b1;
                commit    = din_eop;
                if (din_eop) begin
                    wr_commit_d = wr_tent_q + 1'b1;
                    state_d     = IDLE;
                end
            end
        end else if (din_vld && state_q == DISCARD && din_eop) begin
            state_d  = IDLE;
            drop_inc = 2'd1;
        end
        eop_d = eop_q;
        if (we) eop_d[wa] = din_eop;
        // a shadow of the eop flags lets pkt_cnt drop in the issue cycle itself
        rd_issue   = b_rdy && (rd_ptr_q != wr_commit_q);
        rd_eop     = rd_issue && eop_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d   = rd_ptr_q + PW'(rd_issue);
        dout_vld_d = rd_issue;
        pkt_cnt_d  = pkt_cnt_q + PW'(commit) - PW'(rd_eop);
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_commit_q <= '0;
            wr_tent_q   <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            eop_q       <= '0;
            dout_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_commit_q <= wr_commit_d;
            wr_tent_q   <= wr_tent_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            eop_q       <= eop_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    pkt_sf_ram #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we      (we),
        .wa      (wa),
        .wd      ({din_sop, din_eop, din}),
        .re      (rd_issue),
        .ra      (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_vld_q & rd_data[DATA_W+SOP_BIT];
    assign dout_eop = dout_vld_q & rd_data[DATA_W+EOP_BIT];
    assign dout     = dout_vld_q ? rd_data[DATA_W-1:0] : '0;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: doc/pkt_sf_fifo.md
PKT_SF_FIFO -- requirements
Module: pkt_sf_fifo

Interface
REQ-001 Parameter DATA_W, 8, payload width in bits.
REQ-002 Parameter DEPTH, 256, storage depth in beats; power of two, minimum 16.
REQ-003 Parameter CNT_W, 16, width of the drop counter.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port din_vld, input, 1, input beat valid.
REQ-008 Port din_sop, input, 1, first beat of packet; qualified by din_vld.
REQ-009 Port din_eop, input, 1, last beat of packet; qualified by din_vld.
REQ-010 Port din, input, DATA_W, input payload.
REQ-011 Port b_rdy, input, 1, downstream permits one read per cycle.
REQ-012 Port dout_vld, output, 1, output beat valid.
REQ-013 Port dout_sop, output, 1, output first beat.
REQ-014 Port dout_eop, output, 1, output last beat.
REQ-015 Port dout, output, DATA_W, output payload.
REQ-016 Port pkt_cnt, output, $clog2(DEPTH)+1, complete packets stored.
REQ-017 Port drop_cnt, output, CNT_W, packets dropped since reset; saturates at all-ones.

Function
REQ-018 Store-and-forward: no beat of a packet becomes readable until its eop beat is committed.
REQ-019 Each entry stores {sop, eop, data}; RAM width DATA_W+2.
REQ-020 Pointers: rd_ptr, wr_commit, wr_tent, each $clog2(DEPTH)+1 bits with wrap bit; full when wr_tent-rd_ptr == DEPTH.
REQ-021 Input FSM states: IDLE, WRITE, DISCARD.
REQ-022 IDLE: din_vld&din_sop -> write beat at wr_commit, wr_tent=wr_commit+1; go to WRITE, or commit immediately when din_eop is also set (single-beat packet).
REQ-023 IDLE: din_vld without din_sop -> beat ignored, not counted as a drop.
REQ-024 WRITE: din_vld&!din_sop, not full -> write at wr_tent, wr_tent+1; when din_eop, wr_commit=wr_tent+1, pkt_cnt+1, go to IDLE.
REQ-025 WRITE: beat arrives while full -> wr_tent=wr_commit, go to DISCARD; if that beat has eop, count drop and go to IDLE.
REQ-026 DISCARD: beats ignored; eop beat -> drop_cnt+1, go to IDLE.
REQ-027 WRITE or DISCARD with din_vld&din_sop -> current packet aborted (drop_cnt+1, wr_tent=wr_commit), new packet started same cycle as in REQ-022.
REQ-028 Read issue: in cycle t, when b_rdy=1 and rd_ptr != wr_commit, read rd_ptr, rd_ptr+1.
REQ-029 Read latency 1: dout_vld=1 with dout/dout_sop/dout_eop from that entry in cycle t+1; otherwise dout_vld=0 and dout, dout_sop, dout_eop hold 0.
REQ-030 b_rdy gates issue only; downstream accepts every beat presented with dout_vld.
REQ-031 pkt_cnt decrements when an eop entry is read-issued; simultaneous commit and eop read -> unchanged.
REQ-032 Reads and writes never use the same address in one cycle except for committed data, which is never overwritten before it is read.
REQ-033 Output order is identical to committed input order; dropped packets leave no trace.

Reset
REQ-034 rst=1 asynchronously forces: FSM=IDLE, all pointers 0, pkt_cnt 0, drop_cnt 0, dout_vld/dout_sop/dout_eop 0, dout 0.
REQ-035 A packet in progress at reset is lost and not counted; RAM contents are not cleared.
REQ-036 The first beat after deassertion is sampled on the first rising edge with rst=0.

Structure
REQ-037 Package pkt_sf_fifo_pkg holds the FSM state enum (IDLE/WRITE/DISCARD) and the entry-field index constants (SOP_BIT, EOP_BIT).
REQ-038 Sub-module pkt_sf_ram: simple dual-port RAM, DEPTH x (DATA_W+2), registered read, one clock; all control logic stays in pkt_sf_fifo.

Verification
REQ-039 b_rdy=1, one 191-beat packet din=0..190 -> dout_vld first asserted 2 cycles after the eop input; 191 beats 0..190; sop on 0, eop on 190; pkt_cnt 1->0.
REQ-040 b_rdy=0, two 191-beat packets -> second packet overflows at its beat 65 and is dropped; drop_cnt=1, pkt_cnt=1; then b_rdy=1 -> only the first packet is output.
REQ-041 sop at beat 10 of a packet, then a complete 20-beat packet -> drop_cnt=1; the output is exactly the 20-beat packet.
REQ-042 15 packets of 191 beats with 5-cycle gaps, b_rdy toggling every cycle -> all 2865 beats in order, no drop, pkt_cnt returns to 0.
REQ-043 rst pulsed at beat 50 of a packet with one complete packet stored -> all outputs 0, pkt_cnt=0; a following 8-beat packet is output correctly.
REQ-044 Commit of a 1-beat packet in the same cycle as the read issue of the stored packet's eop -> pkt_cnt stays 1; the next output is the 1-beat packet.
